// File: rtl/siphash_msg_padder.sv
// Message front end for a SipHash core: packs a byte stream little-endian into
// 64-bit words, appends the length byte to the final word and sequences the core.
module siphash_msg_padder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        empty,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        core_ready,
  output logic        core_initalize,
  output logic        core_compress,
  output logic        core_finalize,
  output logic [63:0] core_mi,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INIT       = 4'd1;
  localparam logic [3:0] COLLECT    = 4'd2;
  localparam logic [3:0] SEND       = 4'd3;
  localparam logic [3:0] WAIT_C     = 4'd4;
  localparam logic [3:0] FINAL_SEND = 4'd5;
  localparam logic [3:0] WAIT_F     = 4'd6;
  localparam logic [3:0] FIN        = 4'd7;
  localparam logic [3:0] WAIT_FIN   = 4'd8;

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic        wait_arm;
  logic        empty_q;
  logic        last_q;
  logic [63:0] word_q;
  logic [2:0]  idx_q;
  logic [7:0]  len_q;
  logic        accept;

  // Unused high bytes are already zero because the buffer is cleared after
  // every full word, so only the top byte needs the running length.
  function automatic logic [63:0] pad_final(input logic [63:0] word,
                                            input logic [7:0]  len);
    pad_final = {len, word[55:0]};
  endfunction

  assign accept = (state == COLLECT) && in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = INIT;
      INIT:       if (core_ready) state_nxt = empty_q ? FINAL_SEND : COLLECT;
      COLLECT: begin
        if (accept) begin
          if (idx_q == 3'd7)  state_nxt = SEND;
          else if (in_last)   state_nxt = FINAL_SEND;
        end
      end
      SEND:       if (core_ready) state_nxt = WAIT_C;
      WAIT_C:     if (core_ready && wait_arm) state_nxt = last_q ? FINAL_SEND : COLLECT;
      FINAL_SEND: if (core_ready) state_nxt = WAIT_F;
      WAIT_F:     if (core_ready && wait_arm) state_nxt = FIN;
      FIN:        state_nxt = WAIT_FIN;
      WAIT_FIN:   if (core_ready && wait_arm) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // wait_arm is low on the first cycle of any state, so a WAIT_* state never
  // acts on the core_ready level left over from the pulse that entered it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_arm <= 1'b0;
      empty_q  <= 1'b0;
      last_q   <= 1'b0;
      word_q   <= 64'h0;
      idx_q    <= 3'd0;
      len_q    <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_arm <= (state_nxt == state);
      case (state)
        IDLE: begin
          if (start) begin
            empty_q <= empty;
            last_q  <= 1'b0;
            word_q  <= 64'h0;
            idx_q   <= 3'd0;
            len_q   <= 8'd0;
          end
        end
        COLLECT: begin
          if (accept) begin
            word_q[{idx_q, 3'b000} +: 8] <= in_data;
            idx_q <= idx_q + 3'd1;
            len_q <= len_q + 8'd1;
            if ((idx_q == 3'd7) && in_last) last_q <= 1'b1;
          end
        end
        SEND: begin
          if (core_ready) begin
            word_q <= 64'h0;
            idx_q  <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (state == COLLECT);
  assign core_initalize = (state == INIT) && core_ready;
  assign core_compress  = ((state == SEND) || (state == FINAL_SEND)) && core_ready;
  assign core_finalize  = (state == FIN);
  assign busy           = (state != IDLE);
  assign done           = (state == WAIT_FIN) && wait_arm && core_ready;

  always_comb begin
    core_mi = 64'h0;
    if (core_compress) core_mi = (state == FINAL_SEND) ? pad_final(word_q, len_q) : word_q;
  end

endmodule

// File: tb/tb_siphash_msg_padder.sv
// Scoreboard bench for siphash_msg_padder: expected core events are queued per
// message and a negedge monitor pops and compares them as the DUT emits them.
module tb_siphash_msg_padder;

  logic        clk = 1'b0;
  logic        reset, start, empty, in_valid, in_last, core_ready;
  logic [7:0]  in_data;
  logic        in_ready, core_initalize, core_compress, core_finalize, busy, done;
  logic [63:0] core_mi;

  always #5 clk = ~clk;

  siphash_msg_padder dut (
    .clk(clk), .reset(reset), .start(start), .empty(empty),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .core_ready(core_ready), .core_initalize(core_initalize),
    .core_compress(core_compress), .core_finalize(core_finalize),
    .core_mi(core_mi), .busy(busy), .done(done)
  );

  localparam logic [1:0] EV_INIT = 2'd0, EV_COMP = 2'd1, EV_FIN = 2'd2, EV_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  msg[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ready_mode = 1;   // 1: core always ready, 0: random
  int          hold_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference: floor(n/8) full words, then the 0..7 leftover bytes with n mod 256 on top.
  task automatic push_model();
    int n;
    int nfull;
    logic [63:0] w;
    n = msg.size();
    nfull = n / 8;
    push_ev(EV_INIT, 64'h0);
    for (int wi = 0; wi < nfull; wi++) begin
      w = 64'h0;
      for (int k = 0; k < 8; k++) w = w | (64'(msg[wi*8 + k]) << (8*k));
      push_ev(EV_COMP, w);
    end
    w = 64'h0;
    for (int k = 0; k < n % 8; k++) w = w | (64'(msg[nfull*8 + k]) << (8*k));
    w = w | (64'(n % 256) << 56);
    push_ev(EV_COMP, w);
    push_ev(EV_FIN, 64'h0);
    push_ev(EV_DONE, 64'h0);
  endtask

  initial begin
    core_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        core_ready = 1'b0;
        hold_cnt--;
      end else if (ready_mode == 1) core_ready = 1'b1;
      else core_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic pop_cmp(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", 64'(kind), 64'hff);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (e.kind == EV_COMP && kind == EV_COMP) check("core_mi", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("pulse_exclusive", 64'((32'(core_initalize) + 32'(core_compress) + 32'(core_finalize)) > 1), 64'h0);
      if (!core_compress) check("core_mi_idle", core_mi, 64'h0);
      if (core_initalize) pop_cmp(EV_INIT, 64'h0);
      if (core_compress)  pop_cmp(EV_COMP, core_mi);
      if (core_finalize)  pop_cmp(EV_FIN, 64'h0);
      if (done)           pop_cmp(EV_DONE, 64'h0);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 64'h1, 64'h0);
  endtask

  task automatic feed_byte(input logic [7:0] d, input bit last, input bit hold);
    int t;
    bit acc;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && hold) hold_cnt = 5;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic start_msg();
    @(posedge clk);
    #1;
    start = 1'b1;
    empty = (msg.size() == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    empty = 1'b0;
  endtask

  task automatic run_msg(input bit hold, input bit lat);
    int n;
    n = msg.size();
    wait_idle();
    start_msg();
    for (int i = 0; i < n; i++) begin
      feed_byte(msg[i], i == n - 1, hold && i == 7);
      if (hold && i == 7) begin
        in_valid = 1'b1;
        in_data  = msg[8];
        repeat (5) begin
          @(negedge clk);
          check("hold_no_compress", 64'(core_compress), 64'h0);
          check("hold_in_ready", 64'(in_ready), 64'h0);
        end
        in_valid = 1'b0;
      end
      if (lat && i == n - 1) begin
        @(negedge clk);
        check("last_byte_latency", 64'(core_compress), 64'h1);
      end
    end
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'h0);
    check({tag, "_init"}, 64'(core_initalize), 64'h0);
    check({tag, "_compress"}, 64'(core_compress), 64'h0);
    check({tag, "_finalize"}, 64'(core_finalize), 64'h0);
    check({tag, "_mi"}, core_mi, 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; empty = 1'b0;
    in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Empty message
    msg.delete();
    push_ev(EV_INIT, 0); push_ev(EV_COMP, 64'h0); push_ev(EV_FIN, 0); push_ev(EV_DONE, 0);
    run_msg(1'b0, 1'b0);

    // Three bytes
    msg = '{8'h01, 8'h02, 8'h03};
    push_ev(EV_INIT, 0); push_ev(EV_COMP, 64'h0300000000030201); push_ev(EV_FIN, 0); push_ev(EV_DONE, 0);
    run_msg(1'b0, 1'b1);

    // Exactly one word: length goes in a separate final word
    msg.delete();
    for (int i = 0; i < 8; i++) msg.push_back(8'(i));
    push_ev(EV_INIT, 0); push_ev(EV_COMP, 64'h0706050403020100);
    push_ev(EV_COMP, 64'h0800000000000000); push_ev(EV_FIN, 0); push_ev(EV_DONE, 0);
    run_msg(1'b0, 1'b1);

    // Fifteen bytes
    msg.delete();
    for (int i = 0; i < 15; i++) msg.push_back(8'(i));
    push_ev(EV_INIT, 0); push_ev(EV_COMP, 64'h0706050403020100);
    push_ev(EV_COMP, 64'h0f0e0d0c0b0a0908); push_ev(EV_FIN, 0); push_ev(EV_DONE, 0);
    run_msg(1'b0, 1'b1);

    // 256 bytes, length wraps; core stalls in SEND after the first word
    msg.delete();
    for (int i = 0; i < 256; i++) msg.push_back(8'($urandom));
    push_model();
    run_msg(1'b1, 1'b0);

    // Reset in COLLECT after 3 bytes, then a 1-byte message right after reset
    wait_idle();
    msg = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_ev(EV_INIT, 0);
    start_msg();
    for (int i = 0; i < 3; i++) feed_byte(msg[i], 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b1;
    empty = 1'b0;
    push_ev(EV_INIT, 0); push_ev(EV_COMP, 64'h01000000000000AA); push_ev(EV_FIN, 0); push_ev(EV_DONE, 0);
    @(negedge clk);
    check_outputs_zero("post_reset");
    @(posedge clk);
    #1;
    start = 1'b0;
    feed_byte(8'hAA, 1'b1, 1'b0);
    wait_idle();
    check("reset_queue_drained", 64'(exp_q.size()), 64'h0);

    // Randomized messages with a randomly stalling core
    ready_mode = 0;
    for (int m = 0; m < 25; m++) begin
      msg.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) msg.push_back(8'($urandom));
      push_model();
      run_msg(1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
